// File: rtl/soc_int_mnt.sv
// SoC simulation monitor: pass/fail verdict, hang/timeout watchdogs, console decode, virtual counter.
// Optional console decode is enabled by defining SOC_INT_MNT_CONSOLE_EN.
module soc_int_mnt #(
  parameter logic [31:0] MAX_RUN_CYCLES = 32'h0300_0000,
  parameter int unsigned HANG_WINDOW    = 50000,
  parameter logic [31:0] CONSOLE_ADDR   = 32'h01FF_FFF0,
  parameter logic [63:0] PASS_MAGIC     = 64'h0000_0004_4433_3222,
  parameter logic [63:0] FAIL_MAGIC     = 64'h0000_0023_8234_8720
) (
  input  logic          i_pad_clk,
  input  logic          i_pad_rst,
  input  logic [2:0]    i_retire,
  input  logic [2:0]    i_wb_vld,
  input  logic [63:0]   i_wb_data0,
  input  logic [63:0]   i_wb_data1,
  input  logic [63:0]   i_wb_data2,
  input  logic [31:0]   i_aw_addr,
  input  logic [3:0]    i_aw_len,
  input  logic          i_w_vld,
  input  logic [15:0]   i_w_strb,
  input  logic [127:0]  i_w_data,
  input  logic          i_clk_en,
  output logic          o_con_vld,
  output logic [7:0]    o_con_char,
  output logic          o_pass,
  output logic          o_fail,
  output logic [1:0]    o_fail_code,
  output logic          o_done,
  output logic [31:0]   o_vcnt
);

  localparam logic [31:0] HANG_W = 32'(HANG_WINDOW);

  typedef struct packed {
    logic [2:0]       retire;
    logic [2:0]       wb_vld;
    logic [2:0][63:0] wb_data;
  } s1_t;

  s1_t         s1;
  logic [2:0]  hit_pass, hit_fail;
  logic        ret_any, chk;
  logic [31:0] win_cnt, run_cnt, vcnt;
  logic        win_ret;

  always_ff @(posedge i_pad_clk) begin
    if (i_pad_rst) s1 <= '0;
    else           s1 <= '{retire: i_retire, wb_vld: i_wb_vld,
                           wb_data: {i_wb_data2, i_wb_data1, i_wb_data0}};
  end

  always_comb begin
    hit_pass = '0;
    hit_fail = '0;
    for (int l = 0; l < 3; l++) begin
      hit_pass[l] = s1.wb_vld[l] && (s1.wb_data[l] == PASS_MAGIC);
      hit_fail[l] = s1.wb_vld[l] && (s1.wb_data[l] == FAIL_MAGIC);
    end
  end

  assign ret_any = |s1.retire;
  assign chk     = (win_cnt == HANG_W);
  assign o_done  = o_pass | o_fail;

  // Everything except the virtual counter freezes once a verdict is reached.
  always_ff @(posedge i_pad_clk) begin
    if (i_pad_rst) begin
      o_pass      <= 1'b0;
      o_fail      <= 1'b0;
      o_fail_code <= 2'd0;
      win_cnt     <= 32'd1;
      run_cnt     <= 32'd0;
      win_ret     <= 1'b0;
    end else if (!o_done) begin
      run_cnt <= run_cnt + 32'd1;
      win_cnt <= chk ? 32'd1 : win_cnt + 32'd1;
      // A retire on the check cycle belongs to neither window.
      win_ret <= chk ? 1'b0 : (win_ret | ret_any);
      if (|hit_pass) begin
        o_pass <= 1'b1;
      end else if (|hit_fail) begin
        o_fail      <= 1'b1;
        o_fail_code <= 2'd1;
      end else if (chk && !win_ret) begin
        o_fail      <= 1'b1;
        o_fail_code <= 2'd2;
      end else if (run_cnt > MAX_RUN_CYCLES) begin
        o_fail      <= 1'b1;
        o_fail_code <= 2'd3;
      end
    end
  end

  always_ff @(posedge i_pad_clk) begin
    if (i_pad_rst)                 vcnt <= 32'd0;
    else if (vcnt != 32'hFFFF_FFFF) vcnt <= vcnt + 32'd1;
  end
  assign o_vcnt = vcnt;

`ifdef SOC_INT_MNT_CONSOLE_EN
  logic [31:0]  s1_aw_addr;
  logic [3:0]   s1_aw_len;
  logic         s1_w_vld, s1_clk_en;
  logic [15:0]  s1_w_strb;
  logic [127:0] s1_w_data;
  logic         con_hit, con_sel;
  logic [7:0]   con_byte;
  logic         unused_wdata;

  always_ff @(posedge i_pad_clk) begin
    if (i_pad_rst) begin
      s1_aw_addr <= '0;
      s1_aw_len  <= '0;
      s1_w_vld   <= 1'b0;
      s1_clk_en  <= 1'b0;
      s1_w_strb  <= '0;
      s1_w_data  <= '0;
    end else begin
      s1_aw_addr <= i_aw_addr;
      s1_aw_len  <= i_aw_len;
      s1_w_vld   <= i_w_vld;
      s1_clk_en  <= i_clk_en;
      s1_w_strb  <= i_w_strb;
      s1_w_data  <= i_w_data;
    end
  end

  // Only the low byte of each 32-bit word carries a character.
  always_comb begin
    con_sel  = 1'b1;
    con_byte = 8'd0;
    case (s1_w_strb)
      16'h000F: con_byte = s1_w_data[7:0];
      16'h00F0: con_byte = s1_w_data[39:32];
      16'h0F00: con_byte = s1_w_data[71:64];
      16'hF000: con_byte = s1_w_data[103:96];
      default:  con_sel  = 1'b0;
    endcase
  end

  assign con_hit = con_sel && s1_w_vld && s1_clk_en &&
                   (s1_aw_len == 4'd0) && (s1_aw_addr == CONSOLE_ADDR);
  assign unused_wdata = ^{s1_w_data[127:104], s1_w_data[95:72],
                          s1_w_data[63:40], s1_w_data[31:8]};

  always_ff @(posedge i_pad_clk) begin
    if (i_pad_rst) begin
      o_con_vld  <= 1'b0;
      o_con_char <= 8'd0;
    end else begin
      o_con_vld  <= con_hit;
      o_con_char <= con_hit ? con_byte : 8'd0;
    end
  end
`else
  logic unused_con;
  assign unused_con = ^{i_aw_addr, i_aw_len, i_w_vld, i_w_strb, i_w_data, i_clk_en};
  assign o_con_vld  = 1'b0;
  assign o_con_char = 8'd0;
`endif

endmodule

// File: tb/tb_soc_int_mnt.sv
// Directed self-checking bench for soc_int_mnt (small watchdog limits for short runs).
module tb_soc_int_mnt;

  localparam int unsigned HW  = 200;
  localparam logic [31:0] MRC = 32'd1000;
  localparam logic [63:0] PM  = 64'h0000_0004_4433_3222;
  localparam logic [63:0] FM  = 64'h0000_0023_8234_8720;
`ifdef SOC_INT_MNT_CONSOLE_EN
  localparam bit CON = 1'b1;
`else
  localparam bit CON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   retire, wb_vld;
  logic [63:0]  wb_data0, wb_data1, wb_data2;
  logic [31:0]  aw_addr;
  logic [3:0]   aw_len;
  logic         w_vld, clk_en;
  logic [15:0]  w_strb;
  logic [127:0] w_data;
  logic         con_vld, pass, fail, done;
  logic [7:0]   con_char;
  logic [1:0]   fail_code;
  logic [31:0]  vcnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  soc_int_mnt #(
    .MAX_RUN_CYCLES(MRC), .HANG_WINDOW(HW), .CONSOLE_ADDR(32'h01FF_FFF0),
    .PASS_MAGIC(PM), .FAIL_MAGIC(FM)
  ) dut (
    .i_pad_clk(clk), .i_pad_rst(rst), .i_retire(retire), .i_wb_vld(wb_vld),
    .i_wb_data0(wb_data0), .i_wb_data1(wb_data1), .i_wb_data2(wb_data2),
    .i_aw_addr(aw_addr), .i_aw_len(aw_len), .i_w_vld(w_vld), .i_w_strb(w_strb),
    .i_w_data(w_data), .i_clk_en(clk_en), .o_con_vld(con_vld), .o_con_char(con_char),
    .o_pass(pass), .o_fail(fail), .o_fail_code(fail_code), .o_done(done), .o_vcnt(vcnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Verdict snapshot {pass, fail, code, done} packed for compact checks.
  function automatic logic [63:0] verd();
    return {59'd0, pass, fail, fail_code, done};
  endfunction

  task automatic clr_in();
    retire = '0; wb_vld = '0; wb_data0 = '0; wb_data1 = '0; wb_data2 = '0;
    aw_addr = '0; aw_len = '0; w_vld = 1'b0; clk_en = 1'b0; w_strb = '0; w_data = '0;
  endtask

  // Leaves time just after the reset edge; next posedge is edge 1.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clr_in();
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    step(2);
    // Reset state
    chk("rst_verdict", verd(), 64'h0);
    chk("rst_con", {55'd0, con_vld, con_char}, 64'h0);
    chk("rst_vcnt", vcnt, 64'h0);
    rst = 1'b0;
    step(5);
    chk("vcnt_count", vcnt, 64'd5);

    // Pass on lane 1, verdict at edge 2, then held
    do_reset();
    retire = 3'b001;
    wb_vld = 3'b010; wb_data1 = PM;
    step(1);
    chk("pass_lat1", verd(), 64'h0);
    wb_vld = 3'b100; wb_data2 = FM;
    step(1);
    chk("pass_set", verd(), 64'b10001);
    wb_vld = '0;
    step(10);
    chk("pass_hold", verd(), 64'b10001);

    // Fail magic on lane 2
    do_reset();
    retire = 3'b100;
    wb_vld = 3'b100; wb_data2 = FM;
    step(1);
    wb_vld = '0;
    step(1);
    chk("fail_magic", verd(), 64'b01011);

    // Pass outranks fail in the same cycle
    do_reset();
    retire = 3'b010;
    wb_vld = 3'b101; wb_data0 = PM; wb_data2 = FM;
    step(1);
    wb_vld = '0;
    step(1);
    chk("pass_prio", verd(), 64'b10001);

    // Console: back-to-back valid beats, then an illegal strobe
    do_reset();
    retire = 3'b001;
    aw_addr = 32'h01FF_FFF0; aw_len = 4'd0; w_vld = 1'b1; clk_en = 1'b1;
    w_data = '0; w_data[71:64] = 8'h41; w_data[7:0] = 8'h11; w_data[39:32] = 8'h22;
    w_strb = 16'h0F00;
    step(1);
    chk("con_lat1", {55'd0, con_vld, con_char}, 64'h0);
    w_strb = 16'h000F;
    step(1);
    chk("con_0f00", {55'd0, con_vld, con_char}, CON ? 64'h141 : 64'h0);
    w_strb = 16'h00FF;
    step(1);
    chk("con_000f", {55'd0, con_vld, con_char}, CON ? 64'h111 : 64'h0);
    clr_in();
    retire = 3'b001;
    step(1);
    chk("con_badstrb", {55'd0, con_vld, con_char}, 64'h0);

    // Hang: no retires, first check HW cycles after reset
    do_reset();
    step(HW - 1);
    chk("hang_early", verd(), 64'h0);
    step(1);
    chk("hang_first", verd(), 64'b01101);

    // Hang: one retire inside the first window, fail at second check
    do_reset();
    step(99);
    retire = 3'b100;
    step(1);
    retire = '0;
    step(2 * HW - 101);
    chk("hang2_early", verd(), 64'h0);
    step(1);
    chk("hang2_second", verd(), 64'b01101);

    // Timeout with retire every cycle
    do_reset();
    retire = 3'b111;
    step(int'(MRC));
    chk("tmo_early", verd(), 64'h0);
    step(1);
    chk("tmo_edge", verd(), 64'h0);
    step(1);
    chk("tmo_set", verd(), 64'b01111);
    wb_vld = 3'b001; wb_data0 = PM;
    step(5);
    chk("tmo_frozen", verd(), 64'b01111);
    chk("vcnt_live", vcnt, 64'(MRC) + 64'd7);

    // Virtual counter saturation
    force dut.vcnt = 32'hFFFF_FFFE;
    #1 release dut.vcnt;
    step(1);
    chk("vcnt_sat1", vcnt, 64'hFFFF_FFFF);
    step(2);
    chk("vcnt_sat3", vcnt, 64'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule
